// File: rtl/beam_threshold_loader.sv
// Shadow threshold store and load sequencer for the beamform trigger, plus
// gated per-beam trigger rate scalers in the trigger clock domain.
module beam_threshold_loader #(
    parameter int unsigned NBEAMS         = 8,
    parameter int unsigned THRESH_BITS    = 18,
    parameter int unsigned DEFAULT_THRESH = 9000,
    parameter int unsigned HOLDOFF        = 16,
    parameter int unsigned GATE_CYCLES    = 1000,
    parameter int unsigned SCALER_BITS    = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [$clog2(NBEAMS)-1:0]  cfg_addr_i,
    input  logic [THRESH_BITS-1:0]     cfg_thresh_i,
    input  logic                       cfg_wr_i,
    input  logic                       commit_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [THRESH_BITS-1:0]     thresh_o,
    output logic [NBEAMS-1:0]          thresh_wr_o,
    output logic                       thresh_update_o,
    input  logic [NBEAMS-1:0]          trigger_i,
    input  logic [$clog2(NBEAMS)-1:0]  scaler_addr_i,
    output logic [SCALER_BITS-1:0]     scaler_o,
    output logic                       scaler_valid_o
);
    localparam int unsigned AddrW = $clog2(NBEAMS);
    localparam int unsigned HoldW = $clog2(HOLDOFF + 1);
    localparam int unsigned GateW = $clog2(GATE_CYCLES);
    localparam logic [SCALER_BITS-1:0] CntMax = '1;

    typedef enum logic [2:0] {StInit, StIdle, StLoad, StUpdate, StHold} state_e;

    state_e                 state_q, state_d;
    logic [AddrW-1:0]       idx_q, idx_d, next_idx;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic                   busy_q, busy_d, done_q, done_d, upd_q, upd_d;
    logic [THRESH_BITS-1:0] thresh_q, thresh_d, first_val;
    logic [NBEAMS-1:0]      wr_q, wr_d;
    logic [THRESH_BITS-1:0] shadow_q [NBEAMS];
    logic                   shadow_wr, start;

    assign shadow_wr = cfg_wr_i && !busy_q;
    assign next_idx  = idx_q + AddrW'(1);
    // A write to entry 0 on the commit edge must reach the first strobe.
    assign first_val = (shadow_wr && cfg_addr_i == '0) ? cfg_thresh_i : shadow_q[0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        thresh_d = '0;
        wr_d     = '0;
        upd_d    = 1'b0;
        start    = 1'b0;
        unique case (state_q)
            StInit: start = 1'b1;
            StIdle: start = commit_i && !done_q;
            StLoad: begin
                if (idx_q == AddrW'(NBEAMS - 1)) begin
                    state_d = StUpdate;
                    upd_d   = 1'b1;
                end else begin
                    idx_d    = next_idx;
                    thresh_d = shadow_q[next_idx];
                    wr_d     = NBEAMS'(1) << next_idx;
                end
            end
            StUpdate: begin
                state_d = StHold;
                hold_d  = '0;
            end
            StHold: begin
                if (hold_q == HoldW'(HOLDOFF - 1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: state_d = StInit;
        endcase
        if (start) begin
            state_d  = StLoad;
            idx_d    = '0;
            busy_d   = 1'b1;
            thresh_d = first_val;
            wr_d     = NBEAMS'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StInit;
            idx_q    <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            upd_q    <= 1'b0;
            thresh_q <= '0;
            wr_q     <= '0;
            for (int k = 0; k < NBEAMS; k++) shadow_q[k] <= THRESH_BITS'(DEFAULT_THRESH);
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            upd_q    <= upd_d;
            thresh_q <= thresh_d;
            wr_q     <= wr_d;
            if (shadow_wr) shadow_q[cfg_addr_i] <= cfg_thresh_i;
        end
    end

    // Rate scalers; triggers are blanked while a load or holdoff is running.
    logic [GateW-1:0]       gate_q;
    logic                   gate_term, valid_q;
    logic [SCALER_BITS-1:0] cnt_q [NBEAMS];
    logic [SCALER_BITS-1:0] cnt_next [NBEAMS];
    logic [SCALER_BITS-1:0] lat_q [NBEAMS];
    logic [SCALER_BITS-1:0] scaler_q;

    assign gate_term = (gate_q == GateW'(GATE_CYCLES - 1));

    always_comb begin
        for (int k = 0; k < NBEAMS; k++) begin
            cnt_next[k] = cnt_q[k];
            if (trigger_i[k] && !busy_q && cnt_q[k] != CntMax) begin
                cnt_next[k] = cnt_q[k] + SCALER_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_q   <= '0;
            valid_q  <= 1'b0;
            scaler_q <= '0;
            for (int k = 0; k < NBEAMS; k++) begin
                cnt_q[k] <= '0;
                lat_q[k] <= '0;
            end
        end else begin
            gate_q   <= gate_term ? '0 : gate_q + GateW'(1);
            valid_q  <= gate_term;
            scaler_q <= lat_q[scaler_addr_i];
            for (int k = 0; k < NBEAMS; k++) begin
                cnt_q[k] <= gate_term ? '0 : cnt_next[k];
                if (gate_term) lat_q[k] <= cnt_next[k];
            end
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign thresh_o        = thresh_q;
    assign thresh_wr_o     = wr_q;
    assign thresh_update_o = upd_q;
    assign scaler_o        = scaler_q;
    assign scaler_valid_o  = valid_q;

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Randomized bench for beam_threshold_loader against a cycle-count schedule model.
module tb_beam_threshold_loader;
    localparam int NB = 8;
    localparam int HOLD = 16;
    localparam int G = 1000;
    localparam int DEF = 9000;
    localparam int LAST_BUSY = NB + 1 + HOLD;  // 25
    localparam int DONE_T = LAST_BUSY + 1;     // 26

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  cfg_addr_i = '0;
    logic [17:0] cfg_thresh_i = '0;
    logic        cfg_wr_i = 1'b0;
    logic        commit_i = 1'b0;
    logic [7:0]  trigger_i = '0;
    logic [2:0]  scaler_addr_i = '0;
    logic        busy_o, done_o, thresh_update_o, scaler_valid_o;
    logic [17:0] thresh_o;
    logic [7:0]  thresh_wr_o;
    logic [15:0] scaler_o;

    logic        busy2, done2, upd2, valid2;
    logic [17:0] thresh2;
    logic [7:0]  wr2;
    logic [7:0]  scaler2;

    always #5 clk = ~clk;

    beam_threshold_loader dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_addr_i(cfg_addr_i), .cfg_thresh_i(cfg_thresh_i),
        .cfg_wr_i(cfg_wr_i), .commit_i(commit_i), .busy_o(busy_o), .done_o(done_o),
        .thresh_o(thresh_o), .thresh_wr_o(thresh_wr_o), .thresh_update_o(thresh_update_o),
        .trigger_i(trigger_i), .scaler_addr_i(scaler_addr_i), .scaler_o(scaler_o),
        .scaler_valid_o(scaler_valid_o)
    );

    // Narrow scalers and a short gate so saturation is reached quickly.
    beam_threshold_loader #(.SCALER_BITS(8), .GATE_CYCLES(300)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .cfg_addr_i(3'd0), .cfg_thresh_i(18'd0),
        .cfg_wr_i(1'b0), .commit_i(1'b0), .busy_o(busy2), .done_o(done2),
        .thresh_o(thresh2), .thresh_wr_o(wr2), .thresh_update_o(upd2),
        .trigger_i(8'hFF), .scaler_addr_i(scaler_addr_i), .scaler_o(scaler2),
        .scaler_valid_o(valid2)
    );

    int n_vec = 0;
    int n_err = 0;

    int unsigned m_shadow[NB], m_snap[NB], m_cnt[NB], m_lat[NB];
    int          m_t, m_edge, since_rst;
    bit          m_init, m_valid;
    int unsigned m_scaler;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            m_shadow[k] = DEF;
            m_snap[k]   = 0;
            m_cnt[k]    = 0;
            m_lat[k]    = 0;
        end
        m_t = 0; m_edge = 0; since_rst = 0; m_init = 1; m_valid = 0; m_scaler = 0;
    endtask

    // Drive one cycle of inputs (called just after a negedge), advance the model
    // across the next posedge and compare every output shortly after it.
    task automatic step(input bit wr, input int addr, input int unsigned val, input bit cm,
                        input logic [7:0] trig, input int saddr);
        bit busy_now;
        cfg_wr_i = wr; cfg_addr_i = 3'(addr); cfg_thresh_i = 18'(val);
        commit_i = cm; trigger_i = trig; scaler_addr_i = 3'(saddr);

        busy_now = (m_t >= 1 && m_t <= LAST_BUSY);
        m_scaler = m_lat[saddr];
        if (wr && !busy_now) m_shadow[addr] = val & 32'h3FFFF;
        if (m_init || (m_t == 0 && cm)) begin
            m_snap = m_shadow;
            m_t = 1;
            m_init = 0;
        end else if (m_t == DONE_T) m_t = 0;
        else if (m_t > 0) m_t++;
        for (int k = 0; k < NB; k++)
            if (trig[k] && !busy_now && m_cnt[k] < 65535) m_cnt[k]++;
        m_valid = (m_edge % G == G - 1);
        if (m_valid) begin
            m_lat = m_cnt;
            for (int k = 0; k < NB; k++) m_cnt[k] = 0;
        end
        m_edge++;

        @(posedge clk);
        #1;
        since_rst++;
        check("thresh_wr", thresh_wr_o, (m_t >= 1 && m_t <= NB) ? (32'd1 << (m_t - 1)) : 0);
        check("thresh", thresh_o, (m_t >= 1 && m_t <= NB) ? m_snap[m_t-1] : 0);
        check("update", thresh_update_o, m_t == NB + 1);
        check("busy", busy_o, m_t >= 1 && m_t <= LAST_BUSY);
        check("done", done_o, m_t == DONE_T);
        check("scaler_valid", scaler_valid_o, m_valid);
        check("scaler", scaler_o, m_scaler);
        if (since_rst > 302) check("sat_scaler", scaler2, 255);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, i % NB);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", thresh_wr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_thresh", thresh_o, 0);
        check("rst_update", thresh_update_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Default sequence straight out of reset.
        idle(30);

        // Write entry 3 then commit.
        step(1, 3, 12345, 0, 8'h00, 0);
        step(0, 0, 0, 1, 8'h00, 0);
        idle(30);

        // Commit and write issued mid-LOAD are dropped; simultaneous write+commit in IDLE.
        step(0, 0, 0, 1, 8'h00, 0);
        idle(3);
        step(1, 0, 1, 1, 8'h00, 0);
        idle(30);
        step(0, 0, 0, 1, 8'h00, 0);
        idle(30);
        step(1, 0, 777, 1, 8'h00, 0);
        idle(30);

        // Directed burst on beam 2, then randomized traffic across a gate boundary.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 8'h04, 2);
        for (int i = 0; i < 1200; i++)
            step(($urandom % 6) == 0, $urandom % NB, $urandom, ($urandom % 20) == 0,
                 8'($urandom & $urandom & $urandom), $urandom % NB);

        // Asynchronous reset during the 4th LOAD cycle.
        step(1, 3, 4242, 0, 8'h00, 0);
        step(0, 0, 0, 1, 8'h00, 0);
        while (m_t < 4) step(0, 0, 0, 0, 8'h00, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_wr", thresh_wr_o, 0);
        check("async_rst_thresh", thresh_o, 0);
        check("async_rst_busy", busy_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
